latch_write_arbiter: RTL and testbench
======================================

LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 Parameter PHASE_CYCLES, default 2, cycles each latch enable is held high (legal range 1..15).
REQ-002 Parameter GAP_CYCLES, default 1, non-overlap cycles between enable phases (legal range 1..15).
REQ-003 Clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 ReqA, ReqB  input  1 each  write request from requester A or B.
REQ-006 DataA, DataB  input  8 each  write data from requester A or B.
REQ-007 GntA, GntB  output  1 each  grant; high for the whole served transaction.
REQ-008 DoneA, DoneB  output  1 each  one-cycle completion pulse to the served requester.
REQ-009 D_out  output  8  data presented to the master latch bank.
REQ-010 En_m  output  1  master latch bank enable (transparent when high).
REQ-011 En_s  output  1  slave latch bank enable (transparent when high).
REQ-012 Busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM states SHALL be IDLE, MLOAD, GAP1, SLOAD, GAP2 and DONE.
REQ-014 IDLE with ReqA or ReqB high SHALL transition to MLOAD, latch the winner's data into D_out and assert that winner's Gnt, all on the same edge.
REQ-015 Arbitration SHALL be round-robin: if only one requester is high it wins; if both are high, the requester not served last wins.
REQ-016 The last-served pointer SHALL reset to B, so that A wins the first tie.
REQ-017 MLOAD SHALL last PHASE_CYCLES cycles with En_m=1 and En_s=0.
REQ-018 GAP1 SHALL last GAP_CYCLES cycles with En_m=0 and En_s=0.
REQ-019 SLOAD SHALL last PHASE_CYCLES cycles with En_m=0 and En_s=1.
REQ-020 GAP2 SHALL last GAP_CYCLES cycles with both enables 0.
REQ-021 DONE SHALL last one cycle with the served requester's Done=1, then return to IDLE; the grant drops on that return edge.
REQ-022 En_m and En_s SHALL never be high in the same cycle, and each enable SHALL be preceded and followed by at least GAP_CYCLES cycles with both enables low (IDLE counts as low).
REQ-023 D_out SHALL stay constant from the grant edge through DONE; requester data changes during a transaction SHALL be ignored.
REQ-024 A Req deasserted mid-transaction SHALL NOT abort it; the transaction completes and the Done pulse is still issued.
REQ-025 Arbitration SHALL occur only in IDLE; a Req still high in the cycle after DONE SHALL be treated as a new request.
REQ-026 Arbitration latency SHALL be 1 cycle, measured from the first cycle with Req high in IDLE to Gnt high.
REQ-027 Grant duration SHALL be 2*PHASE_CYCLES + 2*GAP_CYCLES + 1 cycles, which is 7 cycles with the defaults.
REQ-028 At most one of GntA and GntB, and at most one of DoneA and DoneB, SHALL be high in any cycle.
REQ-029 The phase counter SHALL be 4 bits wide, SHALL load to its phase length minus 1 on state entry and SHALL count down to 0; it SHALL never wrap.

Reset
REQ-030 Reset SHALL force IDLE and last-served=B, and SHALL drive GntA=GntB=DoneA=DoneB=En_m=En_s=Busy=0 and D_out=8'h00 from the next edge onward.
REQ-031 Reset asserted mid-transaction SHALL abort it with no Done pulse and both enables low on the following cycle.
REQ-032 Reset SHALL take priority over all other inputs.

Structure
REQ-033 The state encoding and the default PHASE_CYCLES and GAP_CYCLES values SHALL reside in a shared package, lab_ctrl_pkg.
REQ-034 The round-robin winner selection SHALL be a combinational sub-module named rr_arb2.
REQ-035 The FSM, the phase counter and the D_out register SHALL reside in latch_write_arbiter.

Verification
REQ-036 Single request: ReqA=1 with DataA=8'hA5 in IDLE -> GntA high for 7 cycles; En_m in cycles 1-2; En_s in cycles 4-5; DoneA in cycle 7; D_out=8'hA5 throughout.
REQ-037 Tie after reset: ReqA=ReqB=1 held -> A served first, then B, then A, alternating, with one IDLE cycle between grants.
REQ-038 Data change: DataB switched from 8'h3C to 8'hFF one cycle after GntB -> D_out stays 8'h3C until IDLE.
REQ-039 Withdrawn request: ReqA dropped in MLOAD -> the sequence completes and DoneA pulses once.
REQ-040 Reset mid-transaction: Reset=1 in SLOAD -> the next cycle shows all outputs 0 and no Done; a subsequent tie is won by A.
REQ-041 Enable assertion checked across all runs, with PHASE_CYCLES=1, GAP_CYCLES=3 also exercised: En_m & En_s never both high, and at least GAP_CYCLES low cycles separate the enables.

Source files
------------

// File: rtl/lab_ctrl_pkg.sv
// Shared types and defaults for the lab latch-control blocks.
// Holds the arbiter state encoding, the requester identity type and the
// default phase/gap lengths used by latch_write_arbiter.
package lab_ctrl_pkg;

    // Default number of cycles each latch enable stays high.
    localparam int DEFAULT_PHASE_CYCLES = 2;

    // Default number of all-low cycles between enable phases.
    localparam int DEFAULT_GAP_CYCLES = 1;

    // Width of the down-counter that times every state.
    localparam int PHASE_CNT_W = 4;

    // Arbiter FSM states, in the order a transaction walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MLOAD = 3'd1,
        GAP1  = 3'd2,
        SLOAD = 3'd3,
        GAP2  = 3'd4,
        DONE  = 3'd5
    } arb_state_t;

    // Identity of a requester, used both for the winner and the last-served pointer.
    typedef enum logic {
        SERVED_A = 1'b0,
        SERVED_B = 1'b1
    } requester_t;

    // Counter value to load on entry to a state lasting 'cycles' cycles.
    // The counter runs down to zero, so a one-cycle state loads zero.
    function automatic logic [PHASE_CNT_W-1:0] phase_load(input int cycles);
        if (cycles < 1) begin
            return '0;
        end
        return PHASE_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection.
// A lone requester always wins; on a tie the requester that was not
// served most recently wins. Purely combinational.
module rr_arb2
    import lab_ctrl_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  requester_t last_served,
    output logic       valid,
    output requester_t winner
);

    // Pick a winner from the live requests and the last-served pointer.
    always_comb begin
        valid  = req_a | req_b;
        winner = SERVED_A;
        if (req_a && req_b) begin
            winner = (last_served == SERVED_B) ? SERVED_A : SERVED_B;
        end else if (req_b) begin
            winner = SERVED_B;
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates two write requesters onto a master/slave latch pair.
// A granted write captures its data, opens the master bank for
// PHASE_CYCLES, waits GAP_CYCLES, opens the slave bank for PHASE_CYCLES,
// waits GAP_CYCLES again and then pulses Done for one cycle.
module latch_write_arbiter
    import lab_ctrl_pkg::*;
#(
    parameter int PHASE_CYCLES = DEFAULT_PHASE_CYCLES,
    parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ReqA,
    input  logic       ReqB,
    input  logic [7:0] DataA,
    input  logic [7:0] DataB,
    output logic       GntA,
    output logic       GntB,
    output logic       DoneA,
    output logic       DoneB,
    output logic [7:0] D_out,
    output logic       En_m,
    output logic       En_s,
    output logic       Busy
);

    localparam logic [PHASE_CNT_W-1:0] PHASE_LOAD = phase_load(PHASE_CYCLES);
    localparam logic [PHASE_CNT_W-1:0] GAP_LOAD   = phase_load(GAP_CYCLES);

    arb_state_t              state;
    arb_state_t              state_next;
    logic [PHASE_CNT_W-1:0]  phase_cnt;
    logic [PHASE_CNT_W-1:0]  phase_cnt_next;
    requester_t              last_served;
    requester_t              last_served_next;
    logic [7:0]              d_out_q;
    logic [7:0]              d_out_next;
    logic                    arb_valid;
    requester_t              arb_winner;
    logic                    phase_over;

    // The arbiter only looks at requests while the FSM is idle; the
    // winner it reports is consumed by the IDLE branch below.
    rr_arb2 u_rr_arb2 (
        .req_a       (ReqA),
        .req_b       (ReqB),
        .last_served (last_served),
        .valid       (arb_valid),
        .winner      (arb_winner)
    );

    assign phase_over = (phase_cnt == '0);

    // State, counter, pointer and data registers; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            last_served <= SERVED_B;
            d_out_q     <= 8'h00;
        end else begin
            state       <= state_next;
            phase_cnt   <= phase_cnt_next;
            last_served <= last_served_next;
            d_out_q     <= d_out_next;
        end
    end

    // Next-state logic: each timed state runs its counter down to zero,
    // then moves on and reloads the counter for the following state.
    // The last-served pointer doubles as the owner of the running write.
    always_comb begin
        state_next       = state;
        phase_cnt_next   = phase_cnt;
        last_served_next = last_served;
        d_out_next       = d_out_q;
        case (state)
            IDLE: begin
                phase_cnt_next = '0;
                if (arb_valid) begin
                    state_next       = MLOAD;
                    phase_cnt_next   = PHASE_LOAD;
                    last_served_next = arb_winner;
                    d_out_next       = (arb_winner == SERVED_B) ? DataB : DataA;
                end
            end
            MLOAD: begin
                if (phase_over) begin
                    state_next     = GAP1;
                    phase_cnt_next = GAP_LOAD;
                end else begin
                    phase_cnt_next = phase_cnt - 1'b1;
                end
            end
            GAP1: begin
                if (phase_over) begin
                    state_next     = SLOAD;
                    phase_cnt_next = PHASE_LOAD;
                end else begin
                    phase_cnt_next = phase_cnt - 1'b1;
                end
            end
            SLOAD: begin
                if (phase_over) begin
                    state_next     = GAP2;
                    phase_cnt_next = GAP_LOAD;
                end else begin
                    phase_cnt_next = phase_cnt - 1'b1;
                end
            end
            GAP2: begin
                if (phase_over) begin
                    state_next     = DONE;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt - 1'b1;
                end
            end
            DONE: begin
                state_next     = IDLE;
                phase_cnt_next = '0;
            end
            default: begin
                state_next     = IDLE;
                phase_cnt_next = '0;
            end
        endcase
    end

    // Output decode: everything follows from the registered state and owner,
    // so grants, enables and Done never depend on the live request inputs.
    always_comb begin
        GntA  = 1'b0;
        GntB  = 1'b0;
        DoneA = 1'b0;
        DoneB = 1'b0;
        En_m  = 1'b0;
        En_s  = 1'b0;
        Busy  = 1'b0;
        if (state != IDLE) begin
            Busy = 1'b1;
            GntA = (last_served == SERVED_A);
            GntB = (last_served == SERVED_B);
        end
        if (state == MLOAD) begin
            En_m = 1'b1;
        end
        if (state == SLOAD) begin
            En_s = 1'b1;
        end
        if (state == DONE) begin
            DoneA = (last_served == SERVED_A);
            DoneB = (last_served == SERVED_B);
        end
    end

    assign D_out = d_out_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: one instance with default timing and one
// with PHASE_CYCLES=1, GAP_CYCLES=3, both fed the same directed stimulus.
// A transaction-timeline model predicts every output each cycle; directed
// literal expectations on the default instance pin the model down.
module tb_latch_write_arbiter;

    localparam int P0 = 2;
    localparam int G0 = 1;
    localparam int P1 = 1;
    localparam int G1 = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic [7:0] data_b = 8'h00;

    logic [1:0] gnt_a;
    logic [1:0] gnt_b;
    logic [1:0] done_a;
    logic [1:0] done_b;
    logic [1:0] en_m;
    logic [1:0] en_s;
    logic [1:0] busy;
    logic [7:0] d_out [2];

    int checks = 0;
    int failures = 0;
    logic checking = 1'b0;

    // Model state per instance: busy flag, cycle number within the grant,
    // owner of the last grant and the data that must sit on D_out.
    logic       m_busy [2]       = '{1'b0, 1'b0};
    int         m_t [2]          = '{0, 0};
    logic       m_last_b [2]     = '{1'b1, 1'b1};
    logic [7:0] m_dout [2]       = '{8'h00, 8'h00};
    logic       m_dout_valid [2] = '{1'b0, 1'b0};
    int         low_run [2]      = '{15, 15};
    logic [1:0] prev_en [2]      = '{2'b00, 2'b00};

    latch_write_arbiter #(.PHASE_CYCLES(P0), .GAP_CYCLES(G0)) u_dut_default (
        .Clk(clk), .Reset(reset), .ReqA(req_a), .ReqB(req_b),
        .DataA(data_a), .DataB(data_b),
        .GntA(gnt_a[0]), .GntB(gnt_b[0]), .DoneA(done_a[0]), .DoneB(done_b[0]),
        .D_out(d_out[0]), .En_m(en_m[0]), .En_s(en_s[0]), .Busy(busy[0])
    );

    latch_write_arbiter #(.PHASE_CYCLES(P1), .GAP_CYCLES(G1)) u_dut_wide_gap (
        .Clk(clk), .Reset(reset), .ReqA(req_a), .ReqB(req_b),
        .DataA(data_a), .DataB(data_b),
        .GntA(gnt_a[1]), .GntB(gnt_b[1]), .DoneA(done_a[1]), .DoneB(done_b[1]),
        .D_out(d_out[1]), .En_m(en_m[1]), .En_s(en_s[1]), .Busy(busy[1])
    );

    always #5 clk = ~clk;

    function automatic int phase_of(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // Advance the model one clock using the inputs sampled at the edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i]       = 1'b0;
                m_t[i]          = 0;
                m_last_b[i]     = 1'b1;
                m_dout[i]       = 8'h00;
                m_dout_valid[i] = 1'b1;
            end else if (!m_busy[i]) begin
                if (req_a || req_b) begin
                    logic win_b;
                    win_b           = (req_a && req_b) ? !m_last_b[i] : req_b;
                    m_busy[i]       = 1'b1;
                    m_t[i]          = 1;
                    m_last_b[i]     = win_b;
                    m_dout[i]       = win_b ? data_b : data_a;
                    m_dout_valid[i] = 1'b1;
                end
            end else if (m_t[i] == 2 * phase_of(i) + 2 * gap_of(i) + 1) begin
                m_busy[i]       = 1'b0;
                m_t[i]          = 0;
                m_dout_valid[i] = 1'b0;
            end else begin
                m_t[i] = m_t[i] + 1;
            end
        end
    end

    task automatic compare_instance(input int i);
        int p;
        int g;
        int t;
        logic [1:0] cur;
        logic x_en_m;
        logic x_en_s;
        logic x_done;
        p = phase_of(i);
        g = gap_of(i);
        t = m_t[i];
        x_en_m = m_busy[i] && (t >= 1) && (t <= p);
        x_en_s = m_busy[i] && (t >= p + g + 1) && (t <= 2 * p + g);
        x_done = m_busy[i] && (t == 2 * p + 2 * g + 1);
        check_output($sformatf("gnt_a[%0d]", i), {7'b0, gnt_a[i]}, {7'b0, m_busy[i] && !m_last_b[i]});
        check_output($sformatf("gnt_b[%0d]", i), {7'b0, gnt_b[i]}, {7'b0, m_busy[i] && m_last_b[i]});
        check_output($sformatf("done_a[%0d]", i), {7'b0, done_a[i]}, {7'b0, x_done && !m_last_b[i]});
        check_output($sformatf("done_b[%0d]", i), {7'b0, done_b[i]}, {7'b0, x_done && m_last_b[i]});
        check_output($sformatf("en_m[%0d]", i), {7'b0, en_m[i]}, {7'b0, x_en_m});
        check_output($sformatf("en_s[%0d]", i), {7'b0, en_s[i]}, {7'b0, x_en_s});
        check_output($sformatf("busy[%0d]", i), {7'b0, busy[i]}, {7'b0, m_busy[i]});
        if (m_dout_valid[i]) begin
            check_output($sformatf("d_out[%0d]", i), d_out[i], m_dout[i]);
        end
        cur = {en_s[i], en_m[i]};
        check_output($sformatf("en_overlap[%0d]", i), {7'b0, cur == 2'b11}, 8'h00);
        if (cur != 2'b00) begin
            if (prev_en[i] == 2'b00) begin
                check_output($sformatf("en_gap_before[%0d]", i), {7'b0, low_run[i] >= g}, 8'h01);
            end else begin
                check_output($sformatf("en_switch[%0d]", i), {6'b0, cur}, {6'b0, prev_en[i]});
            end
            low_run[i] = 0;
        end else if (low_run[i] < 15) begin
            low_run[i] = low_run[i] + 1;
        end
        prev_en[i] = cur;
    endtask

    // Compare both instances against the model on every cycle after reset.
    always @(posedge clk) begin
        #2;
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                compare_instance(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic rst, input logic ra, input logic rb,
                                  input logic [7:0] da, input logic [7:0] db);
        reset  = rst;
        req_a  = ra;
        req_b  = rb;
        data_a = da;
        data_b = db;
    endtask

    task automatic check_literal(input string tag, input logic ga, input logic gb,
                                 input logic dna, input logic dnb, input logic em,
                                 input logic es, input logic bz);
        check_output({tag, " GntA"}, {7'b0, gnt_a[0]}, {7'b0, ga});
        check_output({tag, " GntB"}, {7'b0, gnt_b[0]}, {7'b0, gb});
        check_output({tag, " DoneA"}, {7'b0, done_a[0]}, {7'b0, dna});
        check_output({tag, " DoneB"}, {7'b0, done_b[0]}, {7'b0, dnb});
        check_output({tag, " En_m"}, {7'b0, en_m[0]}, {7'b0, em});
        check_output({tag, " En_s"}, {7'b0, en_s[0]}, {7'b0, es});
        check_output({tag, " Busy"}, {7'b0, busy[0]}, {7'b0, bz});
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    initial begin
        // Reset state.
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checking = 1'b1;
        idle_cycles(2);
        check_literal("reset", 0, 0, 0, 0, 0, 0, 0);
        check_output("reset D_out", d_out[0], 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // Single request from A, withdrawn during the master phase.
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'hA5, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                req_a = 1'b0;
            end
            check_literal($sformatf("single c%0d", k), 1, 0, k == 7, 0,
                          k <= 2, (k == 4) || (k == 5), 1);
            check_output($sformatf("single c%0d D_out", k), d_out[0], 8'hA5);
        end
        tick();
        check_literal("single idle", 0, 0, 0, 0, 0, 0, 0);
        idle_cycles(12);

        // Tie held right after reset: A, B, A with one idle cycle between.
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        idle_cycles(3);
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h11, 8'h22);
        for (int c = 1; c <= 24; c++) begin
            int ph;
            logic own_a;
            tick();
            ph = (c - 1) % 8;
            own_a = (((c - 1) / 8) % 2) == 0;
            if (ph == 7) begin
                check_literal($sformatf("tie c%0d", c), 0, 0, 0, 0, 0, 0, 0);
            end else begin
                check_literal($sformatf("tie c%0d", c), own_a, !own_a,
                              own_a && ph == 6, !own_a && ph == 6,
                              ph <= 1, (ph == 3) || (ph == 4), 1);
                check_output($sformatf("tie c%0d D_out", c), d_out[0], own_a ? 8'h11 : 8'h22);
            end
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h11, 8'h22);
        idle_cycles(12);

        // Requester data changes after the grant must not reach D_out.
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h3C);
        tick();
        check_literal("datachg c1", 0, 1, 0, 0, 1, 0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
        for (int k = 2; k <= 7; k++) begin
            tick();
            check_output($sformatf("datachg c%0d D_out", k), d_out[0], 8'h3C);
            check_output($sformatf("datachg c%0d GntB", k), {7'b0, gnt_b[0]}, 8'h01);
        end
        check_output("datachg DoneB", {7'b0, done_b[0]}, 8'h01);
        idle_cycles(12);

        // Reset during the slave phase aborts the write without Done.
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h5A, 8'h00);
        tick();
        req_a = 1'b0;
        idle_cycles(3);
        check_literal("abort sload", 1, 0, 0, 0, 0, 1, 1);
        reset = 1'b1;
        tick();
        check_literal("abort reset", 0, 0, 0, 0, 0, 0, 0);
        check_output("abort D_out", d_out[0], 8'h00);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_literal($sformatf("abort idle%0d", k), 0, 0, 0, 0, 0, 0, 0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h66, 8'h77);
        tick();
        check_literal("abort tie", 1, 0, 0, 0, 1, 0, 1);
        check_output("abort tie D_out", d_out[0], 8'h66);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idle_cycles(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
